// File: rtl/response_uart_tx.sv
// Response byte FIFO feeding an 8N1 UART transmitter.
// Code/data bytes from the response handler are queued and sent back to back.
module response_uart_tx #(
    parameter int CLOCKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       response_ready,
    input  logic [7:0] response,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, baud_end;

    logic [7:0]    mem_q [FIFO_DEPTH];

    // Storage has no reset; validity is tracked entirely by the pointers/count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= response;
        end
    end

    always_comb begin
        push       = response_ready && (count_q != FULL_COUNT);
        overflow_d = response_ready && (count_q == FULL_COUNT);
        baud_end   = (baud_q == BAUD_LAST);

        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (baud_end) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d = (count_d == FULL_COUNT);
        busy_d = (state_d != IDLE) || (count_d != '0);

        // Line level is computed from the next state so tx is a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = overflow_q;

endmodule
